// File: rtl/mux_nx1_arb_if.sv
// Handshake bundle for mux_nx1_arb: N_IN producer channels in, one registered consumer channel out.
// The slave side is the mux; the master side drives channel data/valid, mode, sel and out_ready.
interface mux_nx1_arb_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N_IN)
);
  logic [N_IN*WIDTH-1:0] in;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_ch;

  modport master (
    output in, in_valid, mode, sel, out_ready,
    input  in_ready, out, out_valid, out_ch
  );

  modport slave (
    input  in, in_valid, mode, sel, out_ready,
    output in_ready, out, out_valid, out_ch
  );
endinterface

// File: rtl/mux_nx1_arb.sv
// N-input registered mux with fixed-select or round-robin arbitration and valid/ready handshakes.
// Optional transfer counter port xfer_count is enabled by defining MUX_NX1_ARB_COUNT_EN.
module mux_nx1_arb #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_nx1_arb_if.slave  bus
`ifdef MUX_NX1_ARB_COUNT_EN
  ,
  output logic [15:0]   xfer_count
`endif
);

  logic [N_IN-1:0]  grant;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic             can_accept;
  logic             accept;
  logic [SELW-1:0]  rr_idx;
  logic             rr_found;
  logic             fix_ok;
  logic [WIDTH-1:0] sel_data;

  logic [SELW-1:0]  rr_ptr_reg;
  logic [SELW-1:0]  rr_ptr_next;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  out_ch_reg;

  // Round-robin search starts at rr_ptr and wraps modulo N_IN.
  always_comb begin
    int idx;
    idx      = 0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!rr_found && bus.in_valid[idx]) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(idx);
      end
    end
  end

  // An out-of-range sel (non-power-of-2 N_IN) simply yields no grant.
  always_comb begin
    fix_ok = 1'b0;
    if (int'(bus.sel) < N_IN) fix_ok = bus.in_valid[bus.sel];
  end

  assign grant_idx  = bus.mode ? rr_idx : bus.sel;
  assign grant_any  = bus.mode ? rr_found : fix_ok;
  assign can_accept = !out_valid_reg || bus.out_ready;
  assign accept     = grant_any && can_accept;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == SELW'(gi));
    end
  endgenerate

  assign bus.in_ready = rst_n ? (grant & {N_IN{can_accept}}) : '0;
  assign sel_data     = bus.in[int'(grant_idx)*WIDTH +: WIDTH];
  assign rr_ptr_next  = (int'(grant_idx) == N_IN-1) ? '0 : SELW'(grant_idx + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (accept) begin
        out_reg       <= sel_data;
        out_ch_reg    <= grant_idx;
        out_valid_reg <= 1'b1;
        if (bus.mode) rr_ptr_reg <= rr_ptr_next;
      end else if (bus.out_ready) begin
        // Drain without refill: data and channel tag keep their last value.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;

`ifdef MUX_NX1_ARB_COUNT_EN
  logic [15:0] xfer_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_reg <= '0;
    end else if (out_valid_reg && bus.out_ready && (xfer_count_reg != 16'hFFFF)) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: doc/mux_nx1_arb.md
Name: mux_nx1_arb

Overview:
Parametrised N-input, WIDTH-bit multiplexer with a registered output and a valid/ready handshake on every channel. It is the clocked successor of the 2:1 mux in the logic-gate library.
- Selection is either fixed (external sel) or round-robin arbitration among valid inputs.
- Use it wherever several producers share one consumer and the selected channel must be tagged and held stable under backpressure.

Parameters:
- N_IN, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- SELW, $clog2(N_IN), width of sel/out_ch (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N_IN*WIDTH  packed channel data; channel i = in[i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out this cycle.
- out_ch  output  SELW  index of the channel held in out.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, out_ch=0, rr_ptr=0. in_ready is all zero while rst_n is low.
- Transfer rules:
  - An input transfer happens on channel i when in_valid[i] & in_ready[i] at a rising edge.
  - An output transfer happens when out_valid & out_ready.
- can_accept = !out_valid | out_ready, so back-to-back throughput is 1 word/cycle.
- Grant (combinational, at most one bit set):
  - mode=0: grant[sel]=in_valid[sel]. If sel >= N_IN (non-power-of-2 N_IN), no grant.
  - mode=1: grant goes to the first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_IN.
- in_ready[i] = grant[i] & can_accept. No ready is given to a non-granted channel.
- Latency: data accepted at edge k appears on out with out_valid=1 after edge k, i.e. 1 cycle. out_ch is loaded together with out.
- Hold: while out_valid & !out_ready, out and out_ch stay stable and every in_ready is 0.
- Drain with no new grant: out_valid goes to 0 on the next edge. out and out_ch keep their last value.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, with no bubble.
- rr_ptr:
  - Updates only on an input transfer in mode=1, to (granted index + 1) mod N_IN. Wrap: N_IN-1 -> 0.
  - Does not move in mode=0 and is not cleared by a mode change.
- Mode/sel changes take effect in the same-cycle grant computation. They never alter an already-held output.
- All-invalid inputs: no grant, no state change except a drain.
- Reset mid-transfer: the held word is discarded, outputs return to reset values immediately, and rr_ptr=0.

Optional Feature:
- Macro MUX_NX1_ARB_COUNT_EN.
- Defined: adds output port xfer_count (16 bits).
  - Increments on every output transfer.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst_n.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset/idle: rst_n=0 with arbitrary inputs -> out=0, out_valid=0, out_ch=0, in_ready=4'b0000. After release with all in_valid=0 -> out_valid stays 0.
2. Fixed mode: mode=0, sel=2, in_valid=4'b1111, in[ch2]=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out=8'hA5, out_ch=2, out_valid=1. Change sel to 0 with in[ch0]=8'h3C -> next cycle out=8'h3C, out_ch=0.
3. Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,... at 1 word/cycle. With in_valid=4'b1010 from rr_ptr=0 -> out_ch sequence 1,3,1,3.
4. Backpressure: out_valid=1 with out_ch=1, out_ready=0 for 3 cycles while inputs change -> out and out_ch stable, in_ready=0. Raise out_ready -> the next granted word loads on that edge with no bubble.
5. Reset mid-operation: rst_n pulsed low between clock edges while out_valid=1 and rr_ptr=2 -> outputs go to 0 immediately. After release with all channels valid in mode=1 -> first out_ch=0.
6. With MUX_NX1_ARB_COUNT_EN: 5 output transfers -> xfer_count=5. Force 65540 transfers -> xfer_count=16'hFFFF.
